dm_cache_ctrl: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate cache controller for the RISC-V data path.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/cache_tag_store.sv | 50 +++++
 rtl/dm_cache_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped cache controller.
// Address layout is {tag, index, offset}, all in word units.
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WRITE   = 2'd1,
      ST_REFILL  = 2'd2,
      ST_RESPOND = 2'd3
   } state_e;

   function automatic int unsigned off_width(input int unsigned block_words);
      return $clog2(block_words);
   endfunction

   function automatic int unsigned tag_width(input int unsigned addr_w,
                                             input int unsigned index_w,
                                             input int unsigned block_words);
      return addr_w - index_w - $clog2(block_words);
   endfunction

   function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                              input int unsigned off_w,
                                              input int unsigned index_w);
      return (addr >> off_w) & ((32'd1 << index_w) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                            input int unsigned off_w,
                                            input int unsigned index_w);
      return addr >> (off_w + index_w);
   endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag/valid array: asynchronous read, one write port, single-cycle invalidate-all.
// State updates on the falling clock edge to match the controller.
module cache_tag_store #(
   parameter int unsigned INDEX_W = 5,
   parameter int unsigned TAG_W   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INDEX_W-1:0] rd_idx,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   input  logic               wr_en,
   input  logic [INDEX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic               clear
);

   localparam int unsigned LINES = 1 << INDEX_W;

   logic [LINES-1:0] valid_d, valid_q;
   logic [TAG_W-1:0] tag_d [LINES];
   logic [TAG_W-1:0] tag_q [LINES];

   // NOTE: every always_comb target gets its default first, so no path leaves it unassigned (no latch).
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      if (clear) begin
         valid_d = '0;
      end else if (wr_en) begin
         valid_d[wr_idx] = 1'b1;
         tag_d[wr_idx]   = wr_tag;
      end
   end

   // NOTE: sequential blocks use non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) valid_q <= '0;
      else       valid_q <= valid_d;
   end

   // NOTE: the tag array is deliberately not reset; a cleared valid bit makes its contents irrelevant.
   always_ff @(negedge clk) begin
      tag_q <= tag_d;
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with block refill,
// flush and saturating hit/miss counters. All state changes on the falling clock edge.
module dm_cache_ctrl
   import cache_pkg::*;
#(
   parameter  int unsigned ADDR_W      = 10,
   parameter  int unsigned INDEX_W     = 5,
   parameter  int unsigned BLOCK_WORDS = 4,
   parameter  int unsigned PERF_W      = 16,
   localparam int unsigned OFF_W       = off_width(BLOCK_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic              flush,
   input  logic              mem_ready,
   output logic              hit,
   output logic              stall,
   output logic              cache_rd,
   output logic              cache_wr,
   output logic              fill_we,
   output logic [OFF_W-1:0]  fill_off,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [PERF_W-1:0] hit_cnt,
   output logic [PERF_W-1:0] miss_cnt
);

   localparam int unsigned TAG_W = tag_width(ADDR_W, INDEX_W, BLOCK_WORDS);
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

   state_e              state_d, state_q;
   logic [OFF_W-1:0]    beat_d, beat_q;
   logic [PERF_W-1:0]   hit_cnt_d, hit_cnt_q;
   logic [PERF_W-1:0]   miss_cnt_d, miss_cnt_q;

   logic [TAG_W-1:0]    cur_tag;
   logic [INDEX_W-1:0]  cur_index;
   logic                line_valid;
   logic [TAG_W-1:0]    line_tag;
   logic                hit_w;
   logic                tag_we;
   logic                clear_all;

   assign cur_tag   = TAG_W'(addr_tag(32'(cpu_addr), OFF_W, INDEX_W));
   assign cur_index = INDEX_W'(addr_index(32'(cpu_addr), OFF_W, INDEX_W));
   assign hit_w     = line_valid && (line_tag == cur_tag);

   cache_tag_store #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_tag_store (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (cur_index),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .wr_en    (tag_we),
      .wr_idx   (cur_index),
      .wr_tag   (cur_tag),
      .clear    (clear_all)
   );

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      tag_we     = 1'b0;
      clear_all  = 1'b0;
      hit        = hit_w;
      stall      = 1'b0;
      cache_rd   = 1'b0;
      cache_wr   = 1'b0;
      fill_we    = 1'b0;
      fill_off   = '0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (cpu_wr) begin
               mem_wr   = 1'b1;
               mem_addr = cpu_addr;
               cache_wr = hit_w;
               stall    = !mem_ready;
               if (!mem_ready) state_d = ST_WRITE;
            end else if (cpu_rd) begin
               if (hit_w) begin
                  cache_rd  = 1'b1;
                  hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + PERF_W'(1);
               end else begin
                  stall      = 1'b1;
                  beat_d     = '0;
                  state_d    = ST_REFILL;
                  miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + PERF_W'(1);
               end
            end else if (flush) begin
               clear_all = 1'b1;
            end
         end
         ST_WRITE: begin
            mem_wr   = 1'b1;
            mem_addr = cpu_addr;
            stall    = !mem_ready;
            if (mem_ready) state_d = ST_IDLE;
         end
         ST_REFILL: begin
            mem_rd   = 1'b1;
            mem_addr = {cpu_addr[ADDR_W-1:OFF_W], beat_q};
            stall    = 1'b1;
            if (mem_ready) begin
               fill_we  = 1'b1;
               fill_off = beat_q;
               beat_d   = beat_q + OFF_W'(1);
               // Tag and valid are committed only with the final beat, so an aborted fill leaves the line invalid.
               if (beat_q == LAST_BEAT) begin
                  tag_we  = 1'b1;
                  state_d = ST_RESPOND;
               end
            end
         end
         ST_RESPOND: begin
            cache_rd = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are forced quiet while reset is held, whatever the core is requesting.
      if (reset) begin
         hit      = 1'b0;
         stall    = 1'b0;
         cache_rd = 1'b0;
         cache_wr = 1'b0;
         fill_we  = 1'b0;
         fill_off = '0;
         mem_rd   = 1'b0;
         mem_wr   = 1'b0;
         mem_addr = '0;
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: per-cycle expected outputs are queued with the stimulus
// and compared after the DUT has produced them. Counters use a 3-bit width to reach saturation.
module tb_dm_cache_ctrl;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned PERF_W = 3;

   logic              clk;
   logic              reset;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_rd, cpu_wr, flush, mem_ready;
   logic              hit, stall, cache_rd, cache_wr, fill_we;
   logic [1:0]        fill_off;
   logic              mem_rd, mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [PERF_W-1:0] hit_cnt, miss_cnt;

   dm_cache_ctrl #(
      .ADDR_W      (10),
      .INDEX_W     (5),
      .BLOCK_WORDS (4),
      .PERF_W      (PERF_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_rd    (cpu_rd),
      .cpu_wr    (cpu_wr),
      .flush     (flush),
      .mem_ready (mem_ready),
      .hit       (hit),
      .stall     (stall),
      .cache_rd  (cache_rd),
      .cache_wr  (cache_wr),
      .fill_we   (fill_we),
      .fill_off  (fill_off),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic              rd;
      logic              wr;
      logic              fl;
      logic              mr;
      logic [ADDR_W-1:0] addr;
   } stim_t;

   typedef struct packed {
      logic              hit;
      logic              stall;
      logic              cache_rd;
      logic              cache_wr;
      logic              fill_we;
      logic [1:0]        fill_off;
      logic              mem_rd;
      logic              mem_wr;
      logic [ADDR_W-1:0] mem_addr;
   } out_t;

   stim_t stim_q[$];
   out_t  exp_q[$];
   out_t  obs_q[$];
   int    checks = 0;
   int    errors = 0;

   function automatic stim_t st(input logic rd, input logic wr, input logic fl,
                                input logic mr, input logic [ADDR_W-1:0] a);
      stim_t s;
      s.rd = rd; s.wr = wr; s.fl = fl; s.mr = mr; s.addr = a;
      return s;
   endfunction

   function automatic out_t ex(input logic h, input logic stl, input logic crd, input logic cwr,
                               input logic fwe, input logic [1:0] foff, input logic mrd,
                               input logic mwr, input logic [ADDR_W-1:0] ma);
      out_t e;
      e.hit = h; e.stall = stl; e.cache_rd = crd; e.cache_wr = cwr; e.fill_we = fwe;
      e.fill_off = foff; e.mem_rd = mrd; e.mem_wr = mwr; e.mem_addr = ma;
      return e;
   endfunction

   function automatic out_t sample();
      out_t o;
      o.hit = hit; o.stall = stall; o.cache_rd = cache_rd; o.cache_wr = cache_wr;
      o.fill_we = fill_we; o.fill_off = fill_off; o.mem_rd = mem_rd; o.mem_wr = mem_wr;
      o.mem_addr = mem_addr;
      return o;
   endfunction

   task automatic push(input stim_t s, input out_t e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   // Full read miss: one miss cycle, four beats with mem_ready high, then RESPOND with the line now present.
   task automatic push_refill(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] ba;
      push(st(1, 0, 0, 0, a), ex(0, 1, 0, 0, 0, 2'd0, 0, 0, '0));
      for (int b = 0; b < 4; b++) begin
         ba = {a[ADDR_W-1:2], 2'(b)};
         push(st(1, 0, 0, 1, a), ex(0, 1, 0, 0, 1, 2'(b), 1, 0, ba));
      end
      push(st(1, 0, 0, 0, a), ex(1, 0, 1, 0, 0, 2'd0, 0, 0, '0));
   endtask

   // Drives queued stimulus one cycle each: set inputs after the falling edge, sample at the rising edge.
   task automatic play();
      stim_t s;
      while (stim_q.size() != 0) begin
         s = stim_q.pop_front();
         cpu_rd = s.rd; cpu_wr = s.wr; flush = s.fl; mem_ready = s.mr; cpu_addr = s.addr;
         @(posedge clk);
         obs_q.push_back(sample());
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      out_t o;
      reset = 1'b1;
      cpu_rd = 1'b1; cpu_wr = 1'b1; flush = 1'b0; mem_ready = 1'b1; cpu_addr = 10'h085;
      #7;
      o = sample();
      checks++;
      if (o !== out_t'('0)) begin
         errors++;
         $display("FAIL reset_outputs: got %p want all zero", o);
      end
      checks++;
      if (hit_cnt !== 3'd0 || miss_cnt !== 3'd0) begin
         errors++;
         $display("FAIL reset_counters: got hit %0d miss %0d want 0 0", hit_cnt, miss_cnt);
      end
      @(posedge clk);
      reset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic test_refill();
      out_t e, o;
      int n = 0;
      push(st(1, 0, 0, 0, 10'h085), ex(0, 1, 0, 0, 0, 2'd0, 0, 0, '0));
      push(st(1, 0, 0, 1, 10'h085), ex(0, 1, 0, 0, 1, 2'd0, 1, 0, 10'h084));
      push(st(1, 0, 0, 0, 10'h085), ex(0, 1, 0, 0, 0, 2'd0, 1, 0, 10'h085));
      push(st(1, 0, 0, 1, 10'h085), ex(0, 1, 0, 0, 1, 2'd1, 1, 0, 10'h085));
      push(st(1, 0, 0, 1, 10'h085), ex(0, 1, 0, 0, 1, 2'd2, 1, 0, 10'h086));
      push(st(1, 0, 0, 1, 10'h085), ex(0, 1, 0, 0, 1, 2'd3, 1, 0, 10'h087));
      push(st(1, 0, 0, 0, 10'h085), ex(1, 0, 1, 0, 0, 2'd0, 0, 0, '0));
      push(st(0, 0, 0, 0, 10'h085), ex(1, 0, 0, 0, 0, 2'd0, 0, 0, '0));
      play();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (!e.fill_we) o.fill_off = '0;
         if (!(e.mem_rd || e.mem_wr)) o.mem_addr = '0;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL refill step %0d: got %p want %p", n, o, e);
         end
         n++;
      end
      checks++;
      if (miss_cnt !== 3'd1 || hit_cnt !== 3'd0) begin
         errors++;
         $display("FAIL refill_counters: got hit %0d miss %0d want 0 1", hit_cnt, miss_cnt);
      end
   endtask

   task automatic test_read_hit();
      out_t e, o;
      int n = 0;
      push(st(1, 0, 0, 0, 10'h086), ex(1, 0, 1, 0, 0, 2'd0, 0, 0, '0));
      push(st(0, 0, 0, 0, 10'h086), ex(1, 0, 0, 0, 0, 2'd0, 0, 0, '0));
      play();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (!e.fill_we) o.fill_off = '0;
         if (!(e.mem_rd || e.mem_wr)) o.mem_addr = '0;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL read_hit step %0d: got %p want %p", n, o, e);
         end
         n++;
      end
      checks++;
      if (hit_cnt !== 3'd1) begin
         errors++;
         $display("FAIL read_hit_count: got %0d want 1", hit_cnt);
      end
   endtask

   task automatic test_write();
      out_t e, o;
      int n = 0;
      // Store hit with memory slow to accept: array written in the first cycle only, stall for 3 cycles.
      push(st(0, 1, 0, 0, 10'h086), ex(1, 1, 0, 1, 0, 2'd0, 0, 1, 10'h086));
      push(st(0, 1, 0, 0, 10'h086), ex(1, 1, 0, 0, 0, 2'd0, 0, 1, 10'h086));
      push(st(0, 1, 0, 0, 10'h086), ex(1, 1, 0, 0, 0, 2'd0, 0, 1, 10'h086));
      push(st(0, 1, 0, 1, 10'h086), ex(1, 0, 0, 0, 0, 2'd0, 0, 1, 10'h086));
      push(st(0, 0, 0, 0, 10'h086), ex(1, 0, 0, 0, 0, 2'd0, 0, 0, '0));
      // Store miss accepted at once: no array write, and no allocation for a later read.
      push(st(0, 1, 0, 1, 10'h300), ex(0, 0, 0, 0, 0, 2'd0, 0, 1, 10'h300));
      push_refill(10'h300);
      play();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (!e.fill_we) o.fill_off = '0;
         if (!(e.mem_rd || e.mem_wr)) o.mem_addr = '0;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL write step %0d: got %p want %p", n, o, e);
         end
         n++;
      end
      checks++;
      if (miss_cnt !== 3'd2 || hit_cnt !== 3'd1) begin
         errors++;
         $display("FAIL write_counters: got hit %0d miss %0d want 1 2", hit_cnt, miss_cnt);
      end
   endtask

   task automatic test_evict_flush();
      out_t e, o;
      int n = 0;
      push_refill(10'h185);
      push_refill(10'h085);
      push(st(0, 0, 1, 0, 10'h085), ex(1, 0, 0, 0, 0, 2'd0, 0, 0, '0));
      push(st(0, 0, 0, 0, 10'h085), ex(0, 0, 0, 0, 0, 2'd0, 0, 0, '0));
      push_refill(10'h185);
      play();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (!e.fill_we) o.fill_off = '0;
         if (!(e.mem_rd || e.mem_wr)) o.mem_addr = '0;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL evict_flush step %0d: got %p want %p", n, o, e);
         end
         n++;
      end
      checks++;
      if (miss_cnt !== 3'd5) begin
         errors++;
         $display("FAIL evict_flush_misses: got %0d want 5", miss_cnt);
      end
   endtask

   task automatic test_back_to_back();
      out_t e, o;
      int n = 0;
      for (int i = 0; i < 8; i++) begin
         push(st(1, 0, 0, 0, 10'h185), ex(1, 0, 1, 0, 0, 2'd0, 0, 0, '0));
      end
      play();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (!e.fill_we) o.fill_off = '0;
         if (!(e.mem_rd || e.mem_wr)) o.mem_addr = '0;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL back_to_back step %0d: got %p want %p", n, o, e);
         end
         n++;
      end
      // 1 earlier hit + 8 here saturates a 3-bit counter at 7.
      checks++;
      if (hit_cnt !== 3'd7) begin
         errors++;
         $display("FAIL hit_saturate: got %0d want 7", hit_cnt);
      end
   endtask

   task automatic test_reset_mid_refill();
      out_t e, o;
      int n = 0;
      push(st(1, 0, 0, 0, 10'h200), ex(0, 1, 0, 0, 0, 2'd0, 0, 0, '0));
      push(st(1, 0, 0, 1, 10'h200), ex(0, 1, 0, 0, 1, 2'd0, 1, 0, 10'h200));
      play();
      cpu_rd = 1'b1; cpu_wr = 1'b0; flush = 1'b0; mem_ready = 1'b1; cpu_addr = 10'h200;
      #1;
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 10'h201 || fill_off !== 2'd1) begin
         errors++;
         $display("FAIL second_beat: got mem_rd %b addr %h off %0d want 1 201 1", mem_rd, mem_addr, fill_off);
      end
      reset = 1'b1;
      #1;
      o = sample();
      checks++;
      if (o !== out_t'('0)) begin
         errors++;
         $display("FAIL mid_refill_reset_outputs: got %p want all zero", o);
      end
      checks++;
      if (hit_cnt !== 3'd0 || miss_cnt !== 3'd0) begin
         errors++;
         $display("FAIL mid_refill_reset_counters: got hit %0d miss %0d want 0 0", hit_cnt, miss_cnt);
      end
      @(posedge clk);
      reset = 1'b0; cpu_rd = 1'b0;
      @(negedge clk);
      #1;
      push_refill(10'h200);
      play();
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         if (!e.fill_we) o.fill_off = '0;
         if (!(e.mem_rd || e.mem_wr)) o.mem_addr = '0;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_refill step %0d: got %p want %p", n, o, e);
         end
         n++;
      end
      checks++;
      if (miss_cnt !== 3'd1) begin
         errors++;
         $display("FAIL reset_refill_misses: got %0d want 1", miss_cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_refill();
      test_read_hit();
      test_write();
      test_evict_flush();
      test_back_to_back();
      test_reset_mid_refill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
